// File: rtl/pipe_cpu_pkg.sv
// Shared encodings, field slices and decode helpers for the 5-stage forwarding CPU core.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package pipe_cpu_pkg;

    // Opcodes (instr[15:12]); anything not listed behaves as NOP
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_STORE = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_LDI   = 4'h8;
    localparam logic [3:0] OP_BNEZ  = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Instruction field boundaries: opcode | rd | rs1 | rs2
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS1_HI = 7;
    localparam int RS1_LO = 4;
    localparam int RS2_HI = 3;
    localparam int RS2_LO = 0;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    // EX operand source selects
    localparam logic [1:0] FWD_IDEX = 2'd0;
    localparam logic [1:0] FWD_EXM  = 2'd1;
    localparam logic [1:0] FWD_MWB  = 2'd2;

    // Opcodes that write rd in WB
    function automatic logic is_writer(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_LOAD, OP_AND, OP_OR, OP_XOR, OP_LDI: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_cpu_hazard.sv
// Forwarding-source selection plus load-use stall and branch/halt flush generation.
// Latency: purely combinational, same cycle.
// Backpressure: stall holds PC and IF/ID for one cycle; a flush from EX overrides a stall.
module pipe_cpu_hazard
    import pipe_cpu_pkg::*;
(
    input  logic       id_vld,
    input  logic [3:0] id_op,
    input  logic [3:0] id_rd,
    input  logic [3:0] id_rs1,
    input  logic [3:0] id_rs2,
    input  logic       ex_vld,
    input  logic [3:0] ex_op,
    input  logic [3:0] ex_rd,
    input  logic [3:0] ex_ra,
    input  logic [3:0] ex_rb,
    input  logic       exm_vld,
    input  logic [3:0] exm_op,
    input  logic [3:0] exm_rd,
    input  logic       mwb_vld,
    input  logic [3:0] mwb_op,
    input  logic [3:0] mwb_rd,
    input  logic       br_taken,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       halt_ex,
    output logic       flush,
    output logic       stall
);

    logic exm_fwd_ok;
    logic mwb_fwd_ok;
    logic load_use;

    // A LOAD result is not ready until MEM/WB, so EX/MEM only forwards ALU/LDI results
    assign exm_fwd_ok = exm_vld && is_writer(exm_op) && (exm_op != OP_LOAD);
    assign mwb_fwd_ok = mwb_vld && is_writer(mwb_op);

    // Youngest producer wins: EX/MEM, then MEM/WB, then the value read in ID
    always_comb begin
        fwd_a = FWD_IDEX;
        fwd_b = FWD_IDEX;
        if (exm_fwd_ok && exm_rd == ex_ra)      fwd_a = FWD_EXM;
        else if (mwb_fwd_ok && mwb_rd == ex_ra) fwd_a = FWD_MWB;
        if (exm_fwd_ok && exm_rd == ex_rb)      fwd_b = FWD_EXM;
        else if (mwb_fwd_ok && mwb_rd == ex_rb) fwd_b = FWD_MWB;
    end

    // LOAD in EX feeding the instruction in ID costs exactly one bubble;
    // a taken branch or HALT in EX is older, so it wins over the stall
    always_comb begin
        load_use = ex_vld && (ex_op == OP_LOAD) && id_vld &&
                   ((ex_rd == id_rs1) || (ex_rd == id_rs2) ||
                    ((id_op == OP_BNEZ) && (ex_rd == id_rd)));
        halt_ex  = ex_vld && (ex_op == OP_HALT);
        flush    = br_taken || halt_ex;
        stall    = load_use && !flush;
    end

endmodule

// File: rtl/pipe_cpu_fwd.sv
// 5-stage in-order CPU core (IF/ID/EX/MEM/WB) with full forwarding, branch flush and HALT.
// Latency: fetch at edge n -> retire port valid after edge n+3, register file written at n+4.
// Backpressure: none external; load-use inserts one bubble, taken BNEZ/HALT squash IF/ID and ID/EX.
module pipe_cpu_fwd
    import pipe_cpu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 4,
    parameter int DMEM_AW = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               imem_we,
    input  logic [PC_W-1:0]    imem_addr,
    input  logic [15:0]        imem_wdata,
    input  logic               dmem_we,
    input  logic [DMEM_AW-1:0] dmem_addr,
    input  logic [DATA_W-1:0]  dmem_wdata,
    input  logic [3:0]         dbg_addr,
    output logic [DATA_W-1:0]  dbg_rdata,
    output logic               retire_valid,
    output logic [3:0]         retire_rd,
    output logic [DATA_W-1:0]  retire_data,
    output logic               halted
);

    typedef struct packed {
        logic        vld;
        logic [15:0] instr;
    } ifid_t;

    typedef struct packed {
        logic              vld;
        logic [3:0]        op;
        logic [3:0]        rd;
        logic [3:0]        ra;
        logic [3:0]        rb;
        logic [7:0]        imm;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } idex_t;

    typedef struct packed {
        logic               vld;
        logic [3:0]         op;
        logic [3:0]         rd;
        logic [DATA_W-1:0]  res;
        logic [DATA_W-1:0]  sdat;
        logic [DMEM_AW-1:0] addr;
    } exmem_t;

    typedef struct packed {
        logic              vld;
        logic [3:0]        op;
        logic [3:0]        rd;
        logic [DATA_W-1:0] res;
    } memwb_t;

    logic [15:0]       imem [2**PC_W];
    logic [DATA_W-1:0] dmem [2**DMEM_AW];
    logic [DATA_W-1:0] rf   [16];

    logic [PC_W-1:0] pc;
    logic            fetch_off;
    ifid_t           ifid;
    idex_t           idex, id_next;
    exmem_t          exmem, ex_next;
    memwb_t          memwb, mem_next;

    logic [3:0]        id_op, id_rd, id_rs1, id_rs2, id_ra;
    logic [DATA_W-1:0] id_a, id_b, ex_a, ex_b, ex_res;
    logic [1:0]        fwd_a, fwd_b;
    logic              wb_we, host_ok, br_taken, halt_ex, flush, stall;

    assign host_ok = reset || halted;
    assign wb_we   = memwb.vld && is_writer(memwb.op);

    // ID decode; BNEZ tests rd, so it borrows the first read port
    assign id_op  = ifid.instr[OP_HI:OP_LO];
    assign id_rd  = ifid.instr[RD_HI:RD_LO];
    assign id_rs1 = ifid.instr[RS1_HI:RS1_LO];
    assign id_rs2 = ifid.instr[RS2_HI:RS2_LO];
    assign id_ra  = (id_op == OP_BNEZ) ? id_rd : id_rs1;

    // Write-first register file read: a same-cycle WB write is seen by ID
    assign id_a = (wb_we && memwb.rd == id_ra)  ? memwb.res : rf[id_ra];
    assign id_b = (wb_we && memwb.rd == id_rs2) ? memwb.res : rf[id_rs2];

    assign dbg_rdata = rf[dbg_addr];

    // Assemble the ID/EX payload from the decoded fetch word
    always_comb begin
        id_next = '{vld: 1'b1, op: id_op, rd: id_rd, ra: id_ra, rb: id_rs2,
                    imm: ifid.instr[RS1_HI:RS2_LO], a: id_a, b: id_b};
    end

    pipe_cpu_hazard u_hazard (
        .id_vld   (ifid.vld),
        .id_op    (id_op),
        .id_rd    (id_rd),
        .id_rs1   (id_rs1),
        .id_rs2   (id_rs2),
        .ex_vld   (idex.vld),
        .ex_op    (idex.op),
        .ex_rd    (idex.rd),
        .ex_ra    (idex.ra),
        .ex_rb    (idex.rb),
        .exm_vld  (exmem.vld),
        .exm_op   (exmem.op),
        .exm_rd   (exmem.rd),
        .mwb_vld  (memwb.vld),
        .mwb_op   (memwb.op),
        .mwb_rd   (memwb.rd),
        .br_taken (br_taken),
        .fwd_a    (fwd_a),
        .fwd_b    (fwd_b),
        .halt_ex  (halt_ex),
        .flush    (flush),
        .stall    (stall)
    );

    // EX operand muxes driven by the forwarding selects
    always_comb begin
        case (fwd_a)
            FWD_EXM: ex_a = exmem.res;
            FWD_MWB: ex_a = memwb.res;
            default: ex_a = idex.a;
        endcase
        case (fwd_b)
            FWD_EXM: ex_b = exmem.res;
            FWD_MWB: ex_b = memwb.res;
            default: ex_b = idex.b;
        endcase
    end

    // ALU; non-writers produce 0 so the retire port reports 0 for them
    always_comb begin
        case (idex.op)
            OP_ADD:  ex_res = ex_a + ex_b;
            OP_SUB:  ex_res = ex_a - ex_b;
            OP_AND:  ex_res = ex_a & ex_b;
            OP_OR:   ex_res = ex_a | ex_b;
            OP_XOR:  ex_res = ex_a ^ ex_b;
            OP_LDI:  ex_res = DATA_W'(idex.imm);
            OP_NOP, OP_LOAD, OP_STORE, OP_BNEZ, OP_HALT: ex_res = '0;
            default: ex_res = '0;
        endcase
        br_taken = idex.vld && (idex.op == OP_BNEZ) && (ex_a != '0);
        ex_next  = '{vld: idex.vld, op: idex.op, rd: idex.rd, res: ex_res,
                     sdat: ex_b, addr: DMEM_AW'(ex_a)};
    end

    // MEM: combinational data-memory read merged into the writeback value
    always_comb begin
        mem_next = '{vld: exmem.vld, op: exmem.op, rd: exmem.rd, res: exmem.res};
        if (exmem.op == OP_LOAD) mem_next.res = dmem[exmem.addr];
    end

    assign retire_valid = memwb.vld;
    assign retire_rd    = memwb.rd;
    assign retire_data  = memwb.res;

    // Pipeline advance: PC, stage registers, fetch shut-off after HALT, sticky halted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc        <= '0;
            fetch_off <= 1'b0;
            halted    <= 1'b0;
            ifid      <= '{vld: 1'b0, instr: NOP_INSTR};
            idex      <= '0;
            exmem     <= '0;
            memwb     <= '0;
        end else begin
            if (br_taken)
                pc <= PC_W'(idex.imm);
            else if (!(halt_ex || fetch_off || stall))
                pc <= pc + PC_W'(1);

            if (flush || fetch_off)
                ifid <= '{vld: 1'b0, instr: NOP_INSTR};
            else if (!stall)
                ifid <= '{vld: 1'b1, instr: imem[pc]};

            if (flush || stall || !ifid.vld)
                idex <= '0;
            else
                idex <= id_next;

            exmem <= ex_next;
            memwb <= mem_next;

            if (halt_ex)
                fetch_off <= 1'b1;
            if (memwb.vld && memwb.op == OP_HALT)
                halted <= 1'b1;
        end
    end

    // Register file write in WB; reset clears all 16 entries
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (wb_we) begin
            rf[memwb.rd] <= memwb.res;
        end
    end

    // Instruction memory: host loads only while the core is idle
    always_ff @(posedge clk) begin
        if (imem_we && host_ok)
            imem[imem_addr] <= imem_wdata;
    end

    // Data memory: host port while idle, otherwise STORE at the end of MEM
    always_ff @(posedge clk) begin
        if (dmem_we && host_ok)
            dmem[dmem_addr] <= dmem_wdata;
        else if (exmem.vld && exmem.op == OP_STORE)
            dmem[exmem.addr] <= exmem.sdat;
    end

endmodule

// File: tb/tb_pipe_cpu_fwd.sv
// Scoreboard bench for pipe_cpu_fwd: expected retires queued per program, checked on the retire port.
// Latency: checks first-retire latency, stall bubble, halt timing.
// Backpressure: n/a.
module tb_pipe_cpu_fwd;

    localparam int DATA_W  = 8;
    localparam int PC_W    = 4;
    localparam int DMEM_AW = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               imem_we = 1'b0;
    logic [PC_W-1:0]    imem_addr = '0;
    logic [15:0]        imem_wdata = '0;
    logic               dmem_we = 1'b0;
    logic [DMEM_AW-1:0] dmem_addr = '0;
    logic [DATA_W-1:0]  dmem_wdata = '0;
    logic [3:0]         dbg_addr = '0;
    logic [DATA_W-1:0]  dbg_rdata;
    logic               retire_valid;
    logic [3:0]         retire_rd;
    logic [DATA_W-1:0]  retire_data;
    logic               halted;

    pipe_cpu_fwd #(.DATA_W(DATA_W), .PC_W(PC_W), .DMEM_AW(DMEM_AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dbg_addr     (dbg_addr),
        .dbg_rdata    (dbg_rdata),
        .retire_valid (retire_valid),
        .retire_rd    (retire_rd),
        .retire_data  (retire_data),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rd;
        logic [7:0] data;
    } exp_t;

    exp_t        sb[$];
    int          ret_cyc[$];
    int          cyc = 0;
    int          rel_cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic [15:0] prog [16];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] rd, input logic [7:0] lo);
        return {op, rd, lo};
    endfunction

    // Retire monitor: every retire must match the head of the scoreboard
    always @(negedge clk) begin
        if (!reset && retire_valid) begin
            ret_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                check_val("unexpected_retire_sb_size", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_val("ret_rd", {28'd0, retire_rd}, {28'd0, e.rd});
                check_val("ret_data", {24'd0, retire_data}, {24'd0, e.data});
            end
        end
    end

    task automatic exp_ret(input logic [3:0] rd, input logic [7:0] d);
        exp_t e;
        e.rd = rd;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 16'hF000;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            imem_we = 1'b1;
            imem_addr = 4'(i);
            imem_wdata = prog[i];
        end
        @(negedge clk);
        imem_we = 1'b0;
    endtask

    task automatic host_dmem(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        dmem_we = 1'b1;
        dmem_addr = a;
        dmem_wdata = d;
        @(negedge clk);
        dmem_we = 1'b0;
    endtask

    task automatic go_reset();
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
    endtask

    task automatic start_run();
        ret_cyc.delete();
        reset = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] idx, input logic [7:0] exp);
        dbg_addr = idx;
        #1;
        check_val(tag, {24'd0, dbg_rdata}, {24'd0, exp});
    endtask

    task automatic run_to_halt(input string tag);
        int n = 0;
        while (!halted && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_halted"}, {31'd0, halted}, 1);
        if (ret_cyc.size() > 0)
            check_val({tag, "_halt_after_retire"}, cyc - ret_cyc[ret_cyc.size()-1], 1);
        repeat (4) @(negedge clk);
        check_val({tag, "_sb_left"}, sb.size(), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_retire_valid", {31'd0, retire_valid}, 0);
        check_val("rst_retire_rd", {28'd0, retire_rd}, 0);
        check_val("rst_retire_data", {24'd0, retire_data}, 0);
        check_val("rst_halted", {31'd0, halted}, 0);
        chk_reg("rst_r5", 4'd5, 8'd0);

        // T1: back-to-back dependent ALU ops, no stalls
        clear_prog();
        prog[0] = enc(4'h8, 4'd2, 8'd10);
        prog[1] = enc(4'h8, 4'd3, 8'd5);
        prog[2] = enc(4'h1, 4'd1, 8'h23);
        prog[3] = enc(4'h2, 4'd4, 8'h13);
        load_prog();
        exp_ret(2, 10); exp_ret(3, 5); exp_ret(1, 15); exp_ret(4, 10); exp_ret(0, 0);
        start_run();
        run_to_halt("t1");
        check_val("t1_nret", ret_cyc.size(), 5);
        if (ret_cyc.size() == 5) begin
            check_val("t1_first_latency", ret_cyc[0] - rel_cyc, 4);
            check_val("t1_consecutive", ret_cyc[3] - ret_cyc[0], 3);
        end
        chk_reg("t1_r1", 4'd1, 8'd15);
        chk_reg("t1_r4", 4'd4, 8'd10);

        // T2: load-use, exactly one bubble
        go_reset();
        host_dmem(4'd10, 8'd77);
        clear_prog();
        prog[0] = enc(4'h8, 4'd2, 8'd10);
        prog[1] = enc(4'h3, 4'd5, 8'h20);
        prog[2] = enc(4'h1, 4'd6, 8'h55);
        load_prog();
        exp_ret(2, 10); exp_ret(5, 77); exp_ret(6, 154); exp_ret(0, 0);
        start_run();
        run_to_halt("t2");
        check_val("t2_nret", ret_cyc.size(), 4);
        if (ret_cyc.size() == 4)
            check_val("t2_one_bubble", ret_cyc[2] - ret_cyc[1], 2);
        chk_reg("t2_r5", 4'd5, 8'd77);
        chk_reg("t2_r6", 4'd6, 8'd154);

        // T3: STORE then LOAD same address
        go_reset();
        clear_prog();
        prog[0] = enc(4'h8, 4'd7, 8'd3);
        prog[1] = enc(4'h8, 4'd8, 8'd99);
        prog[2] = enc(4'h4, 4'd0, 8'h78);
        prog[3] = enc(4'h3, 4'd9, 8'h70);
        load_prog();
        exp_ret(7, 3); exp_ret(8, 99); exp_ret(0, 0); exp_ret(9, 99); exp_ret(0, 0);
        start_run();
        run_to_halt("t3");
        chk_reg("t3_r9", 4'd9, 8'd99);

        // T4a/T4b: BNEZ taken squashes shadow, not taken falls through
        for (int t = 0; t < 2; t++) begin
            go_reset();
            clear_prog();
            prog[0] = enc(4'h8, 4'd1, (t == 0) ? 8'd1 : 8'd0);
            prog[1] = enc(4'h9, 4'd1, 8'd6);
            prog[2] = enc(4'h8, 4'd5, 8'd7);
            prog[3] = enc(4'h8, 4'd6, 8'd8);
            prog[6] = enc(4'h8, 4'd2, 8'd42);
            load_prog();
            if (t == 0) begin
                exp_ret(1, 1); exp_ret(1, 0); exp_ret(2, 42); exp_ret(0, 0);
            end else begin
                exp_ret(1, 0); exp_ret(1, 0); exp_ret(5, 7); exp_ret(6, 8); exp_ret(0, 0);
            end
            start_run();
            run_to_halt((t == 0) ? "t4a" : "t4b");
            check_val("t4_nret", ret_cyc.size(), (t == 0) ? 4 : 5);
            chk_reg("t4_r2", 4'd2, (t == 0) ? 8'd42 : 8'd0);
            chk_reg("t4_r5", 4'd5, (t == 0) ? 8'd0 : 8'd7);
            chk_reg("t4_r6", 4'd6, (t == 0) ? 8'd0 : 8'd8);
        end

        // T5: wrap-around add, HALT stops younger instructions
        go_reset();
        clear_prog();
        prog[0] = enc(4'h8, 4'd3, 8'd200);
        prog[1] = enc(4'h1, 4'd3, 8'h33);
        prog[2] = 16'hF000;
        prog[3] = enc(4'h8, 4'd4, 8'd1);
        load_prog();
        exp_ret(3, 200); exp_ret(3, 144); exp_ret(0, 0);
        start_run();
        run_to_halt("t5");
        repeat (6) @(negedge clk);
        check_val("t5_nret", ret_cyc.size(), 3);
        chk_reg("t5_r3", 4'd3, 8'd144);
        chk_reg("t5_r4", 4'd4, 8'd0);
        check_val("t5_halted_sticky", {31'd0, halted}, 1);

        // T6: mid-run reset, then re-execution of T1 program
        go_reset();
        clear_prog();
        prog[0] = enc(4'h8, 4'd2, 8'd10);
        prog[1] = enc(4'h8, 4'd3, 8'd5);
        prog[2] = enc(4'h1, 4'd1, 8'h23);
        prog[3] = enc(4'h2, 4'd4, 8'h13);
        load_prog();
        exp_ret(2, 10); exp_ret(3, 5); exp_ret(1, 15); exp_ret(4, 10); exp_ret(0, 0);
        start_run();
        repeat (5) @(negedge clk);
        chk_reg("t6_mid_r2", 4'd2, 8'd10);
        reset = 1'b1;
        sb.delete();
        #1;
        check_val("t6_rst_halted", {31'd0, halted}, 0);
        check_val("t6_rst_retire_valid", {31'd0, retire_valid}, 0);
        for (int r = 0; r < 16; r++) chk_reg("t6_rst_reg", 4'(r), 8'd0);
        @(negedge clk);
        exp_ret(2, 10); exp_ret(3, 5); exp_ret(1, 15); exp_ret(4, 10); exp_ret(0, 0);
        start_run();
        run_to_halt("t6");
        check_val("t6_nret", ret_cyc.size(), 5);
        chk_reg("t6_r1", 4'd1, 8'd15);
        chk_reg("t6_r4", 4'd4, 8'd10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
